// File: rtl/cb_config_loader_if.sv
// Byte-stream handshake between the bitstream source and the connection-block
// configuration loader.
interface cb_config_loader_if;
  logic       cfg_start;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (output cfg_start, cfg_data, cfg_valid, input cfg_ready);
  modport slave  (input cfg_start, cfg_data, cfg_valid, output cfg_ready);
endinterface

// File: rtl/cb_config_loader.sv
// Assembles a 10-byte configuration frame in a shadow register, validates pad
// bits and XOR checksum, then commits all 69 bits to prog on a single edge.
module cb_config_loader #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic               clb_clk,
  input  logic               clb_rst,
  cb_config_loader_if.slave  cfg,
  output logic [68:0]        prog,
  output logic               prog_valid,
  output logic               busy,
  output logic               cfg_done,
  output logic               cfg_err,
  output logic [1:0]         err_code
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CSUM,
    COMMIT,
    ERROR
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [68:0] shadow;
  logic [3:0]  byte_cnt;
  logic [7:0]  run_xor;
  logic        pad_err;
  logic [15:0] tmo_cnt;
  logic [1:0]  err_pend;

  logic        accept;
  logic        restart;
  logic [1:0]  err_sel;

  always_ff @(posedge clb_clk) begin
    if (clb_rst) state <= IDLE;
    else         state <= next_state;
  end

  // A start pulse mid-frame restarts silently and blocks the coincident byte.
  always_comb begin
    next_state    = state;
    restart       = 1'b0;
    err_sel       = 2'b00;
    cfg.cfg_ready = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        if (cfg.cfg_start) begin
          next_state = LOAD;
          restart    = 1'b1;
        end
      end
      LOAD, CSUM: begin
        cfg.cfg_ready = !cfg.cfg_start;
        if (cfg.cfg_start) begin
          next_state = LOAD;
          restart    = 1'b1;
        end else if (tmo_cnt == 16'(TIMEOUT)) begin
          next_state = ERROR;
          err_sel    = 2'b11;
        end else if (cfg.cfg_valid) begin
          if (state == LOAD) begin
            if (byte_cnt == 4'd8) next_state = CSUM;
          end else if (pad_err) begin
            next_state = ERROR;
            err_sel    = 2'b10;
          end else if (cfg.cfg_data != run_xor) begin
            next_state = ERROR;
            err_sel    = 2'b01;
          end else begin
            next_state = COMMIT;
          end
        end
      end
      COMMIT, ERROR: next_state = IDLE;
      default:       next_state = IDLE;
    endcase
    accept = cfg.cfg_valid && cfg.cfg_ready;
  end

  always_ff @(posedge clb_clk) begin
    if (clb_rst) begin
      shadow     <= '0;
      byte_cnt   <= '0;
      run_xor    <= '0;
      pad_err    <= 1'b0;
      tmo_cnt    <= '0;
      err_pend   <= 2'b00;
      prog       <= '0;
      prog_valid <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;

      if (restart) begin
        byte_cnt <= '0;
        run_xor  <= '0;
        pad_err  <= 1'b0;
        tmo_cnt  <= '0;
      end else if (state == LOAD || state == CSUM) begin
        if (accept) begin
          tmo_cnt <= '0;
          if (state == LOAD) begin
            if (byte_cnt == 4'd8) begin
              shadow[68:64] <= cfg.cfg_data[4:0];
              if (|cfg.cfg_data[7:5]) pad_err <= 1'b1;
            end else begin
              shadow[{byte_cnt[2:0], 3'b000} +: 8] <= cfg.cfg_data;
            end
            run_xor  <= run_xor ^ cfg.cfg_data;
            byte_cnt <= byte_cnt + 4'd1;
          end
        end else begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
      end

      if (state != ERROR && next_state == ERROR) err_pend <= err_sel;

      if (state == COMMIT) begin
        prog       <= shadow;
        prog_valid <= 1'b1;
        cfg_done   <= 1'b1;
        err_code   <= 2'b00;
      end

      if (state == ERROR) begin
        err_code <= err_pend;
        cfg_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cb_config_loader.sv
// Directed bench for cb_config_loader: frame outcomes are queued when a frame is
// driven and checked when cfg_done or cfg_err pulses.
module tb_cb_config_loader;

  typedef struct packed {
    logic        done;
    logic        err;
    logic [1:0]  code;
    logic [68:0] prog;
    logic        pv;
  } exp_t;

  logic        clb_clk;
  logic        clb_rst;
  logic [68:0] prog;
  logic        prog_valid;
  logic        busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [1:0]  err_code;

  cb_config_loader_if cfg_if ();

  cb_config_loader #(.TIMEOUT(16)) dut (
    .clb_clk    (clb_clk),
    .clb_rst    (clb_rst),
    .cfg        (cfg_if),
    .prog       (prog),
    .prog_valid (prog_valid),
    .busy       (busy),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .err_code   (err_code)
  );

  initial clb_clk = 1'b0;
  always #5 clb_clk = ~clb_clk;

  int unsigned cyc;
  initial cyc = 0;
  always @(posedge clb_clk) cyc <= cyc + 1;

  int unsigned n_cmp;
  int unsigned n_mis;
  exp_t        sb[$];
  logic [7:0]  fr [10];
  logic [68:0] exp_prog;
  logic        exp_pv;
  int unsigned start_cyc;
  int unsigned evt_cyc;

  task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clb_clk);
    #1;
  endtask

  task automatic start_frame();
    cfg_if.cfg_start = 1'b1;
    tick();
    cfg_if.cfg_start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cfg_if.cfg_data  = b;
    cfg_if.cfg_valid = 1'b1;
    tick();
  endtask

  // Reference outcome of the frame in fr, given the currently active prog.
  task automatic push_frame_model();
    logic [7:0]  x;
    logic [68:0] p;
    exp_t        e;
    x = 8'h00;
    p = '0;
    for (int i = 0; i < 9; i++) x = x ^ fr[i];
    for (int i = 0; i < 8; i++) p[i*8 +: 8] = fr[i];
    p[68:64] = fr[8][4:0];
    e.prog = exp_prog;
    e.pv   = exp_pv;
    e.done = 1'b0;
    e.err  = 1'b1;
    if (fr[8][7:5] != 3'b000)  e.code = 2'b10;
    else if (fr[9] != x)       e.code = 2'b01;
    else begin
      e.done = 1'b1;
      e.err  = 1'b0;
      e.code = 2'b00;
      e.prog = p;
      e.pv   = 1'b1;
      exp_prog = p;
      exp_pv   = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic send_frame();
    push_frame_model();
    for (int i = 0; i < 10; i++) send_byte(fr[i]);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int unsigned budget);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      if (cfg_done || cfg_err) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    evt_cyc = cyc;
    check({tag, "_seen"}, 69'(seen), 69'(1));
    if (seen) begin
      check({tag, "_sb_nonempty"}, 69'(sb.size() != 0), 69'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_done"}, 69'(cfg_done), 69'(e.done));
        check({tag, "_err"}, 69'(cfg_err), 69'(e.err));
        check({tag, "_code"}, 69'(err_code), 69'(e.code));
        check({tag, "_prog"}, prog, e.prog);
        check({tag, "_pv"}, 69'(prog_valid), 69'(e.pv));
      end
      tick();
      check({tag, "_pulse_once"}, 69'(cfg_done | cfg_err), 69'(0));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    exp_prog = '0;
    exp_pv   = 1'b0;
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 8'h00;
    clb_rst = 1'b1;
    repeat (3) tick();
    check("rst_prog", prog, '0);
    check("rst_pv", 69'(prog_valid), 69'(0));
    check("rst_ready", 69'(cfg_if.cfg_ready), 69'(0));
    check("rst_busy", 69'(busy), 69'(0));
    check("rst_done", 69'(cfg_done), 69'(0));
    check("rst_err", 69'(cfg_err), 69'(0));
    check("rst_code", 69'(err_code), 69'(0));
    clb_rst = 1'b0;
    tick();

    // All-ones frame; done must appear 11 edges after the start edge.
    for (int i = 0; i < 8; i++) fr[i] = 8'hFF;
    fr[8] = 8'h1F;
    fr[9] = 8'h1F;
    start_frame();
    check("busy_after_start", 69'(busy), 69'(1));
    send_frame();
    wait_result("ones", 8);
    check("ones_latency", 69'(evt_cyc - start_cyc), 69'(11));
    check("ones_value", prog, 69'h1F_FFFF_FFFF_FFFF_FFFF);

    // Bad checksum (correct would be 08).
    for (int i = 0; i < 8; i++) fr[i] = 8'(i + 1);
    fr[8] = 8'h00;
    fr[9] = 8'h00;
    start_frame();
    send_frame();
    wait_result("csum", 8);

    // Pad bits set with matching checksum: pad wins.
    for (int i = 0; i < 8; i++) fr[i] = 8'h00;
    fr[8] = 8'h3F;
    fr[9] = 8'h3F;
    start_frame();
    send_frame();
    wait_result("pad", 8);

    // Timeout after three bytes.
    start_frame();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    cfg_if.cfg_valid = 1'b0;
    sb.push_back('{done: 1'b0, err: 1'b1, code: 2'b11, prog: exp_prog, pv: exp_pv});
    wait_result("tmo", 40);
    check("tmo_busy", 69'(busy), 69'(0));
    check("tmo_ready", 69'(cfg_if.cfg_ready), 69'(0));

    for (int i = 0; i < 9; i++) fr[i] = 8'(8'h5A + 8'(i * 7));
    fr[9] = 8'h00;
    for (int i = 0; i < 9; i++) fr[9] = fr[9] ^ fr[i];
    start_frame();
    send_frame();
    wait_result("after_tmo", 8);

    // Restart mid-frame with a coincident byte that must be dropped.
    start_frame();
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i));
    cfg_if.cfg_start = 1'b1;
    cfg_if.cfg_data  = 8'hAA;
    cfg_if.cfg_valid = 1'b1;
    tick();
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    check("restart_no_err", 69'(cfg_err), 69'(0));
    check("restart_busy", 69'(busy), 69'(1));
    for (int i = 0; i < 9; i++) fr[i] = 8'(8'h10 + 8'(i * 8'h11));
    fr[8] = 8'h0F;
    fr[9] = 8'h00;
    for (int i = 0; i < 9; i++) fr[9] = fr[9] ^ fr[i];
    send_frame();
    wait_result("restart", 8);

    // Reset mid-frame clears the committed configuration.
    start_frame();
    for (int i = 0; i < 4; i++) send_byte(8'h77);
    cfg_if.cfg_data = 8'h55;
    clb_rst = 1'b1;
    tick();
    exp_prog = '0;
    exp_pv   = 1'b0;
    check("mrst_prog", prog, exp_prog);
    check("mrst_pv", 69'(prog_valid), 69'(exp_pv));
    check("mrst_busy", 69'(busy), 69'(0));
    clb_rst = 1'b0;
    tick();
    check("mrst_ready_stall", 69'(cfg_if.cfg_ready), 69'(0));
    check("mrst_no_done", 69'(cfg_done), 69'(0));
    cfg_if.cfg_valid = 1'b0;
    tick();
    check("sb_drained", 69'(sb.size()), 69'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
